// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port main-RAM arbiter:
// controller state encoding, the registered command, default geometry.
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_RAM_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Command captured on accept; sized by the package defaults, so the
   // arbiter's ADDR_W/DATA_W are expected to match these.
   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the main-RAM arbiter: two request/response ports.
// master = requesters (cache refill path, loader/debug), slave = arbiter.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) ();

   logic              req0_valid;
   logic              req0_ready;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              rsp0_valid;
   logic [DATA_W-1:0] rsp0_rdata;

   logic              req1_valid;
   logic              req1_ready;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp1_rdata;

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_rdata
   );

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_rdata
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// port that did not win last time is chosen. Purely combinational.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_gnt,
   output logic winner,
   output logic any
);

   // pick the winner from the valids and the previous grant
   always_comb begin
      any    = valid0 | valid1;
      winner = (valid0 && valid1) ? ~last_gnt : valid1;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester controller for the single-port main RAM behind L1.
// One transaction in flight: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> RESP.
// Optional statistics outputs are enabled by defining RAM_ARB_STATS_EN.
module ram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RAM_LAT = DEF_RAM_LAT,
   parameter int CNT_W   = 16
) (
   input  logic              clock,
   input  logic              resetn,
   ram_port_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  gnt0_cnt,
   output logic [CNT_W-1:0]  gnt1_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
`endif
);

   localparam int CW = $clog2(RAM_LAT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(RAM_LAT - 1);

   arb_state_t        state, state_nx;
   cmd_t              cmd_q;
   logic              gnt_q;
   logic              last_gnt;
   logic              winner;
   logic              any_valid;
   logic              accept;
   logic              wait_done;
   logic [CW-1:0]     wait_cnt;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   rr_arb2 u_rr_arb2 (
      .valid0   (bus.req0_valid),
      .valid1   (bus.req1_valid),
      .last_gnt (last_gnt),
      .winner   (winner),
      .any      (any_valid)
   );

   assign accept    = (state == IDLE) && any_valid;
   assign wait_done = (state == WAIT) && (wait_cnt == WAIT_LAST);

   // state register
   always_ff @(posedge clock) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // next state and all combinational outputs
   always_comb begin
      state_nx       = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      ram_wren       = 1'b0;
      busy           = (state != IDLE);
      case (state)
         IDLE: begin
            bus.req0_ready = ~winner;
            bus.req1_ready = winner;
            if (any_valid) state_nx = ISSUE;
         end
         ISSUE: begin
            ram_wren = cmd_q.we;
            state_nx = WAIT;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) state_nx = RESP;
         end
         RESP: begin
            bus.rsp0_valid = ~gnt_q;
            bus.rsp1_valid = gnt_q;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // grant bookkeeping and the RAM-latency counter
   always_ff @(posedge clock) begin
      if (!resetn) begin
         last_gnt <= 1'b1;
         gnt_q    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (accept) begin
            last_gnt <= winner;
            gnt_q    <= winner;
         end
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // command register; its fields drive the RAM and hold between transactions
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cmd_q <= '0;
      end else if (accept) begin
         cmd_q.we    <= winner ? bus.req1_we    : bus.req0_we;
         cmd_q.addr  <= winner ? bus.req1_addr  : bus.req0_addr;
         cmd_q.wdata <= winner ? bus.req1_wdata : bus.req0_wdata;
      end
   end

   assign ram_address = cmd_q.addr;
   assign ram_data    = cmd_q.wdata;

   // read data captured on the last WAIT edge; writes leave it untouched
   always_ff @(posedge clock) begin
      if (!resetn) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (wait_done && !cmd_q.we) begin
         if (gnt_q) rdata1_q <= ram_q;
         else       rdata0_q <= ram_q;
      end
   end

   assign bus.rsp0_rdata = rdata0_q;
   assign bus.rsp1_rdata = rdata1_q;

`ifdef RAM_ARB_STATS_EN
   // saturating grant and conflict counters
   always_ff @(posedge clock) begin
      if (!resetn) begin
         gnt0_cnt     <= '0;
         gnt1_cnt     <= '0;
         conflict_cnt <= '0;
      end else begin
         if (accept && !winner && (gnt0_cnt != '1)) gnt0_cnt <= gnt0_cnt + 1'b1;
         if (accept &&  winner && (gnt1_cnt != '1)) gnt1_cnt <= gnt1_cnt + 1'b1;
         if ((state == IDLE) && bus.req0_valid && bus.req1_valid && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, scoreboard of expected
// responses built at accept time from a word-array model of memory.
module tb_ram_port_arbiter;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 8;
   localparam int RAM_LAT = 1;
   localparam int CNT_W   = 16;

   logic              clock;
   logic              resetn;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;
   logic              busy;
`ifdef RAM_ARB_STATS_EN
   logic [CNT_W-1:0]  gnt0_cnt, gnt1_cnt, conflict_cnt;
`endif

   ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .bus         (bus),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .busy        (busy)
`ifdef RAM_ARB_STATS_EN
      ,
      .gnt0_cnt     (gnt0_cnt),
      .gnt1_cnt     (gnt1_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // behavioural single-port RAM with RAM_LAT read latency
   logic [DATA_W-1:0] ram_mem [32];
   logic [DATA_W-1:0] qpipe [RAM_LAT];
   always @(posedge clock) begin
      qpipe[0] <= ram_mem[ram_address];
      for (int i = 1; i < RAM_LAT; i++) qpipe[i] <= qpipe[i-1];
      if (ram_wren) ram_mem[ram_address] <= ram_data;
   end
   assign ram_q = qpipe[RAM_LAT-1];

   // reference model: memory contents, per-port last read data, arbitration memory
   typedef struct {
      int                cyc;
      logic [DATA_W-1:0] rd;
   } exp_t;

   exp_t              q0[$];
   exp_t              q1[$];
   int                acc_log[$];
   logic [DATA_W-1:0] model_mem [32];
   logic [DATA_W-1:0] model_rd0, model_rd1;
   int                model_last = 1;
   int                busy_until = 0;
   bit                wren_pend  = 0;
   int                wren_cyc;
   logic [ADDR_W-1:0] wren_addr;
   logic [DATA_W-1:0] wren_data;

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram_mem[i]   = '0;
         model_mem[i] = '0;
      end
      model_rd0 = '0;
      model_rd1 = '0;
   end

   // monitor: checks outputs against the model and records accepts
   always @(negedge clock) begin
      bit idle;
      int p;
      exp_t e;
      if (resetn) begin
         if (wren_pend && (cyc == wren_cyc)) begin
            chk("wren_pulse", ram_wren, 1);
            chk("wren_addr", ram_address, wren_addr);
            chk("wren_data", ram_data, wren_data);
            wren_pend = 0;
         end else begin
            chk("wren_quiet", ram_wren, 0);
         end

         if ((q0.size() > 0) && (q0[0].cyc == cyc)) begin
            e = q0.pop_front();
            chk("rsp0_valid", bus.rsp0_valid, 1);
            chk("rsp0_rdata", bus.rsp0_rdata, e.rd);
         end else begin
            chk("rsp0_quiet", bus.rsp0_valid, 0);
         end
         if ((q1.size() > 0) && (q1[0].cyc == cyc)) begin
            e = q1.pop_front();
            chk("rsp1_valid", bus.rsp1_valid, 1);
            chk("rsp1_rdata", bus.rsp1_rdata, e.rd);
         end else begin
            chk("rsp1_quiet", bus.rsp1_valid, 0);
         end

         idle = (cyc >= busy_until);
         chk("busy", busy, !idle);
         if (bus.req0_valid)
            chk("ready0", bus.req0_ready, idle && (!bus.req1_valid || model_last == 1));
         if (bus.req1_valid)
            chk("ready1", bus.req1_ready, idle && (!bus.req0_valid || model_last == 0));

         p = -1;
         if (bus.req0_valid && bus.req0_ready) p = 0;
         else if (bus.req1_valid && bus.req1_ready) p = 1;
         if (p >= 0) begin
            logic              we;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            we = (p == 0) ? bus.req0_we    : bus.req1_we;
            a  = (p == 0) ? bus.req0_addr  : bus.req1_addr;
            d  = (p == 0) ? bus.req0_wdata : bus.req1_wdata;
            acc_log.push_back(p);
            model_last = p;
            busy_until = cyc + 3 + RAM_LAT;
            if (we) begin
               model_mem[a] = d;
               wren_pend    = 1;
               wren_cyc     = cyc + 1;
               wren_addr    = a;
               wren_data    = d;
            end else begin
               if (p == 0) model_rd0 = model_mem[a];
               else        model_rd1 = model_mem[a];
            end
            e.cyc = cyc + 2 + RAM_LAT;
            e.rd  = (p == 0) ? model_rd0 : model_rd1;
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end else begin
         q0.delete();
         q1.delete();
         wren_pend  = 0;
         model_last = 1;
         model_rd0  = '0;
         model_rd1  = '0;
         busy_until = cyc + 1;
      end
   end

   function automatic logic rdy(input int p);
      return (p == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   task automatic drive(input int p, input logic v, input logic we,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (p == 0) begin
         bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
      end
   endtask

   // present one command, called just after a rising edge; returns after accept or abort
   task automatic send(input int p, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit may_abort);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      drive(p, 1'b1, we, a, d);
      while (!done) begin
         @(negedge clock);
         if (resetn && rdy(p)) begin
            done = 1;
         end else begin
            n++;
            if (n > 200) begin
               fail_now($sformatf("accept_timeout port%0d", p));
               done = 1;
            end else if (may_abort) begin
               done = 1;
            end
         end
         @(posedge clock);
         #1;
      end
      drive(p, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_rsp0", bus.rsp0_valid, 0);
      chk("rst_rsp1", bus.rsp1_valid, 0);
      chk("rst_rd0", bus.rsp0_rdata, 0);
      chk("rst_rd1", bus.rsp1_rdata, 0);
`ifdef RAM_ARB_STATS_EN
      chk("rst_gnt0", gnt0_cnt, 0);
      chk("rst_gnt1", gnt1_cnt, 0);
      chk("rst_conf", conflict_cnt, 0);
`endif
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      @(posedge clock);
      #1;
      do_reset();

      // write then read back the same word from the other port
      send(0, 1'b1, 5'd3, 8'hA5, 0);
      idle_cycles(6);
      send(1, 1'b0, 5'd3, 8'h00, 0);
      idle_cycles(6);
      chk("t2_rd1", bus.rsp1_rdata, 8'hA5);
      chk("t2_rd0", bus.rsp0_rdata, 8'h00);

      // ties after reset: port 0 first, then port 1, next tie back to port 0
      do_reset();
      acc_log.delete();
      fork
         send(0, 1'b0, 5'd1, 8'h00, 0);
         send(1, 1'b0, 5'd2, 8'h00, 0);
      join
      idle_cycles(6);
      fork
         send(0, 1'b0, 5'd2, 8'h00, 0);
         send(1, 1'b0, 5'd1, 8'h00, 0);
      join
      idle_cycles(6);
      chk("t3_n", acc_log.size(), 4);
      if (acc_log.size() == 4) begin
         chk("t3_g0", acc_log[0], 0);
         chk("t3_g1", acc_log[1], 1);
         chk("t3_g2", acc_log[2], 0);
      end

      // both held valid for four transactions: grants alternate
      do_reset();
      acc_log.delete();
      fork
         begin
            send(0, 1'b1, 5'd4, 8'h11, 0);
            send(0, 1'b0, 5'd5, 8'h00, 0);
         end
         begin
            send(1, 1'b0, 5'd4, 8'h00, 0);
            send(1, 1'b1, 5'd5, 8'h22, 0);
         end
      join
      idle_cycles(6);
      chk("t4_n", acc_log.size(), 4);
      for (int i = 0; i < acc_log.size(); i++)
         chk($sformatf("t4_g%0d", i), acc_log[i], i % 2);
`ifdef RAM_ARB_STATS_EN
      chk("t6_gnt0", gnt0_cnt, 2);
      chk("t6_gnt1", gnt1_cnt, 2);
      chk("t6_conf_ge3", conflict_cnt >= 3, 1);
`endif

      // reset during WAIT of a port-0 read drops it
      send(0, 1'b0, 5'd4, 8'h00, 0);
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      @(negedge clock);
      chk("t5_busy", busy, 0);
      chk("t5_rsp0", bus.rsp0_valid, 0);
      @(posedge clock);
      #1;
      send(0, 1'b0, 5'd4, 8'h00, 0);
      idle_cycles(6);
      chk("t5_rd0", bus.rsp0_rdata, 8'h11);

      // randomized traffic from both ports on a small address window
      fork
         for (int i = 0; i < 30; i++) begin
            idle_cycles($urandom_range(0, 3));
            send(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 8'($urandom), ($urandom_range(0, 7) == 0));
         end
         for (int j = 0; j < 30; j++) begin
            idle_cycles($urandom_range(0, 3));
            send(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 8'($urandom), ($urandom_range(0, 7) == 0));
         end
      join
      idle_cycles(10);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
